// File: rtl/y86_mem_port_arbiter.sv
// Round-robin arbiter that shares the y86 unified memory port between fetch,
// memory stage and loader. Each access runs through IDLE -> ACCESS -> RESP.
module y86_mem_port_arbiter #(
    parameter int WIDTH    = 64,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req,
    input  logic [2:0]           we,
    input  logic [3*WIDTH-1:0]   addr_flat,
    input  logic [3*WIDTH-1:0]   wdata_flat,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_ready,
    output logic [1:0]           sel,
    output logic [WIDTH-1:0]     rdata,
    output logic [2:0]           ack,
    output logic                 err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_rr_ptr;
    logic [7:0]             r_wait_cnt;
    logic [1:0]             r_sel;
    logic                   r_we;
    logic                   r_err;
    logic [WIDTH-1:0]       r_addr;
    logic [WIDTH-1:0]       r_wdata;
    logic [WIDTH-1:0]       r_rdata;

    logic [2:0]             w_rot_req;
    logic [1:0]             w_offset;
    logic [2:0]             w_win_sum;
    logic [1:0]             w_win;
    logic [WIDTH-1:0]       w_mux_addr;
    logic [WIDTH-1:0]       w_mux_wdata;
    logic                   w_mux_we;
    logic                   w_grant;
    logic                   w_done_ok;
    logic                   w_timeout;
    logic                   w_resp;

    // Rotate requests so the current round-robin head sits at bit 0, then
    // take the lowest set bit as the offset from the head.
    always_comb begin
        w_rot_req = req;
        case (r_rr_ptr)
            2'd1:    w_rot_req = {req[0], req[2], req[1]};
            2'd2:    w_rot_req = {req[1], req[0], req[2]};
            default: w_rot_req = req;
        endcase

        w_offset = 2'd2;
        if (w_rot_req[0]) begin
            w_offset = 2'd0;
        end else if (w_rot_req[1]) begin
            w_offset = 2'd1;
        end

        w_win_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        w_win     = 2'd0;
        case (w_win_sum)
            3'd0:    w_win = 2'd0;
            3'd1:    w_win = 2'd1;
            3'd2:    w_win = 2'd2;
            3'd3:    w_win = 2'd0;
            3'd4:    w_win = 2'd1;
            default: w_win = 2'd0;
        endcase
    end

    always_comb begin
        w_mux_addr  = addr_flat[WIDTH-1:0];
        w_mux_wdata = wdata_flat[WIDTH-1:0];
        w_mux_we    = we[0];
        case (w_win)
            2'd1: begin
                w_mux_addr  = addr_flat[2*WIDTH-1:WIDTH];
                w_mux_wdata = wdata_flat[2*WIDTH-1:WIDTH];
                w_mux_we    = we[1];
            end
            2'd2: begin
                w_mux_addr  = addr_flat[3*WIDTH-1:2*WIDTH];
                w_mux_wdata = wdata_flat[3*WIDTH-1:2*WIDTH];
                w_mux_we    = we[2];
            end
            default: begin
                w_mux_addr  = addr_flat[WIDTH-1:0];
                w_mux_wdata = wdata_flat[WIDTH-1:0];
                w_mux_we    = we[0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        w_resp      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                busy   = 1'b1;
                if (mem_ready) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_wait_cnt == LP_LAST_WAIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy        = 1'b1;
                w_resp      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 2'd0;
            r_wait_cnt <= 8'd0;
            r_sel      <= 2'd0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_addr     <= w_mux_addr;
                r_wdata    <= w_mux_wdata;
                r_we       <= w_mux_we;
                r_sel      <= w_win + 2'd1;
                r_wait_cnt <= 8'd0;
                r_err      <= 1'b0;
            end
            if (w_done_ok) begin
                r_err <= 1'b0;
                if (!r_we) begin
                    r_rdata <= mem_rdata;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end else if (r_state == ST_ACCESS) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // The head moves to the requester after the winner; sel itself
            // already equals winner+1, with 3 wrapping to 0.
            if (w_resp) begin
                r_rr_ptr <= (r_sel == 2'd3) ? 2'd0 : r_sel;
                r_sel    <= 2'd0;
            end
        end
    end

    always_comb begin
        ack = 3'b000;
        if (r_state == ST_RESP) begin
            case (r_sel)
                2'd1:    ack = 3'b001;
                2'd2:    ack = 3'b010;
                2'd3:    ack = 3'b100;
                default: ack = 3'b000;
            endcase
        end
    end

    assign err       = (r_state == ST_RESP) && r_err;
    assign sel       = r_sel;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_y86_mem_port_arbiter.sv
// Testbench for y86_mem_port_arbiter: directed table, hand sequences and
// random transactions checked against a transaction-level model.
module tb_y86_mem_port_arbiter;

    localparam int W  = 64;
    localparam int MW = 8;

    logic           clk;
    logic           rst_n;
    logic [2:0]     req;
    logic [2:0]     we;
    logic [3*W-1:0] addr_flat;
    logic [3*W-1:0] wdata_flat;
    logic           mem_en;
    logic           mem_we;
    logic [W-1:0]   mem_addr;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_rdata;
    logic           mem_ready;
    logic [1:0]     sel;
    logic [W-1:0]   rdata;
    logic [2:0]     ack;
    logic           err;
    logic           busy;

    y86_mem_port_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr_flat  (addr_flat),
        .wdata_flat (wdata_flat),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sel        (sel),
        .rdata      (rdata),
        .ack        (ack),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  w;
        int          d;
        logic [63:0] wd;
        int          exp_win;
        logic        exp_err;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          m_rr  = 0;
    logic [63:0] m_rdata = '0;
    vec_t        tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic int rr_pick(input logic [2:0] r, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    // One transaction from the IDLE cycle to the following IDLE cycle.
    // d = cycle index within ACCESS at which mem_ready is raised (>= MW never).
    task automatic run_txn(input logic [2:0] r, input logic [2:0] w, input int d,
                           input int ew, input logic ee, input logic [63:0] rd);
        logic [63:0] ea;
        logic [63:0] ewd;
        bit          fin;
        req = r;
        we = w;
        mem_ready = 1'b0;
        if (ew < 0) begin
            @(posedge clk); #1;
            chk("idle_sel", 64'(sel), 64'd0);
            chk("idle_en", 64'(mem_en), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            return;
        end
        ea  = addr_flat[ew*W +: W];
        ewd = wdata_flat[ew*W +: W];
        @(posedge clk); #1;
        fin = 1'b0;
        for (int c = 0; c < MW && !fin; c++) begin
            chk("acc_en", 64'(mem_en), 64'd1);
            chk("acc_sel", 64'(sel), 64'(ew + 1));
            chk("acc_we", 64'(mem_we), 64'(w[ew]));
            chk("acc_addr", mem_addr, ea);
            chk("acc_wdata", mem_wdata, ewd);
            chk("acc_ack", 64'(ack), 64'd0);
            chk("acc_busy", 64'(busy), 64'd1);
            req = 3'($urandom);
            we = 3'($urandom);
            addr_flat = {r64(), r64(), r64()};
            wdata_flat = {r64(), r64(), r64()};
            if (c == d) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
                if (!w[ew]) m_rdata = rd;
                fin = 1'b1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = r64();
            end
            @(posedge clk); #1;
        end
        req = 3'b000;
        mem_ready = 1'($urandom);
        chk("resp_ack", 64'(ack), 64'(3'b001 << ew));
        chk("resp_err", 64'(err), 64'(ee));
        chk("resp_en", 64'(mem_en), 64'd0);
        chk("resp_busy", 64'(busy), 64'd1);
        chk("resp_rdata", rdata, m_rdata);
        chk("resp_sel", 64'(sel), 64'(ew + 1));
        @(posedge clk); #1;
        chk("post_sel", 64'(sel), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_ack", 64'(ack), 64'd0);
        chk("post_err", 64'(err), 64'd0);
        m_rr = (ew + 1) % 3;
    endtask

    initial begin
        logic [2:0] rr;
        logic [2:0] rw;
        int         rd_dly;
        int         win;

        tbl[0]  = '{3'b111, 3'b000, 0, 64'h11, 1, 1'b0};
        tbl[1]  = '{3'b111, 3'b111, 0, 64'h22, 2, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 0, 64'h33, 0, 1'b0};
        tbl[3]  = '{3'b111, 3'b000, 0, 64'h44, 1, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, 0, 64'h55, 2, 1'b0};
        tbl[5]  = '{3'b010, 3'b010, 4, 64'd3, 1, 1'b0};
        tbl[6]  = '{3'b100, 3'b000, MW, 64'h77, 2, 1'b1};
        tbl[7]  = '{3'b111, 3'b000, 2, 64'h88, 0, 1'b0};
        tbl[8]  = '{3'b000, 3'b000, 0, 64'h99, -1, 1'b0};
        tbl[9]  = '{3'b101, 3'b001, 1, 64'haa, 2, 1'b0};
        tbl[10] = '{3'b110, 3'b000, MW - 1, 64'hbb, 1, 1'b0};
        tbl[11] = '{3'b011, 3'b000, 0, 64'hcc, 0, 1'b0};
        tbl[12] = '{3'b001, 3'b000, MW + 1, 64'hdd, 0, 1'b1};

        rst_n = 1'b1;
        req = '0;
        we = '0;
        addr_flat = '0;
        wdata_flat = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_en", 64'(mem_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("quiet_sel", 64'(sel), 64'd0);
            chk("quiet_en", 64'(mem_en), 64'd0);
            chk("quiet_ack", 64'(ack), 64'd0);
            chk("quiet_busy", 64'(busy), 64'd0);
        end

        // Single read of requester 0 returning -2.
        addr_flat = {r64(), r64(), 64'h100};
        wdata_flat = {r64(), r64(), r64()};
        run_txn(3'b001, 3'b000, 0, 0, 1'b0, 64'hffff_ffff_ffff_fffe);
        chk("read_m2", rdata, 64'hffff_ffff_ffff_fffe);

        foreach (tbl[i]) begin
            addr_flat = {r64(), r64(), r64()};
            wdata_flat = {3{tbl[i].wd}};
            run_txn(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].exp_win, tbl[i].exp_err, r64());
        end

        for (int i = 0; i < 60; i++) begin
            rr = 3'($urandom_range(0, 7));
            rw = 3'($urandom_range(0, 7));
            rd_dly = $urandom_range(0, MW + 2);
            win = (rr == 3'b000) ? -1 : rr_pick(rr, m_rr);
            addr_flat = {r64(), r64(), r64()};
            wdata_flat = {r64(), r64(), r64()};
            run_txn(rr, rw, rd_dly, win, (rd_dly >= MW), r64());
        end

        // Reset in the middle of an access by requester 1.
        req = 3'b010;
        we = 3'b000;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_sel", 64'(sel), 64'd2);
        @(posedge clk); #1;
        chk("pre_rst_en", 64'(mem_en), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 64'(sel), 64'd0);
        chk("mid_rst_en", 64'(mem_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", mem_addr, 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_ack", 64'(ack), 64'd0);
        rst_n = 1'b1;
        m_rr = 0;
        m_rdata = '0;
        addr_flat = {r64(), r64(), r64()};
        wdata_flat = {r64(), r64(), r64()};
        run_txn(3'b011, 3'b000, 0, 0, 1'b0, r64());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_mem_port_arbiter.md
Name: y86_mem_port_arbiter

Overview:
Shares the single unified memory port of the y86 core between three requesters: 0 = fetch, 1 = memory stage, 2 = loader/debug. A round-robin arbiter grants one requester at a time. A 3-way WIDTH-bit address/write-data mux, controlled by the registered grant, drives the port. A small FSM sequences each access through a ready handshake with a timeout, then returns read data and a one-cycle ack to the winner.

Parameters:
WIDTH, 64, address and data width in bits (signed two's-complement data is passed through unmodified).
MAX_WAIT, 8, maximum cycles ACCESS waits for mem_ready before aborting with err; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  3  per-requester request; held high until that requester's ack
we  input  3  per-requester write enable; sampled with req
addr_flat  input  3*WIDTH  requester i address in bits [i*WIDTH +: WIDTH]
wdata_flat  input  3*WIDTH  requester i write data, same packing
mem_en  output  1  memory access strobe
mem_we  output  1  memory write strobe
mem_addr  output  WIDTH  muxed address
mem_wdata  output  WIDTH  muxed write data
mem_rdata  input  WIDTH  memory read data; valid when mem_ready=1
mem_ready  input  1  memory completion for the current access
sel  output  2  grant code: 0 = none, 1/2/3 = requester 0/1/2
rdata  output  WIDTH  captured read data
ack  output  3  one-hot completion pulse to the winner
err  output  1  timeout flag, coincident with ack
busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, wait_cnt=0.
  - sel=0; mem_en, mem_we, ack, err, busy = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Reset mid-ACCESS or mid-RESP aborts the transaction with no ack.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req != 0, choose the winner by round-robin, searching from rr_ptr upward mod 3.
  - On that clock edge, register the winner's addr, wdata and we, and set sel = winner+1.
  - Go to ACCESS with wait_cnt=0. If req == 0, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we = the latched we.
  - mem_addr and mem_wdata hold the latched values and stay stable for the whole state; req changes do not affect them.
  - If mem_ready=1: if the access is a read, capture mem_rdata into rdata; go to RESP with err=0.
  - If mem_ready=0 and wait_cnt == MAX_WAIT-1: go to RESP with err=1; rdata is unchanged.
  - Otherwise increment wait_cnt and stay in ACCESS.
- RESP (one cycle):
  - ack[sel-1]=1; err as set on entry; mem_en=0.
  - rr_ptr = (winner+1) mod 3; sel=0 on exit; go to IDLE.
- Writes never modify rdata. rdata holds its value until the next successful read.
- Latency: req sampled in IDLE at edge N gives mem_en high in cycle N+1. With mem_ready in that cycle, ack is high in cycle N+2 and the next grant happens at edge N+3. Minimum 3 cycles per transaction.
- Requests are evaluated only in IDLE. req changes during ACCESS/RESP do not affect the current transaction.
- A requester that drops req before its ack still receives the ack.
- A requester must deassert req in the cycle after its ack, or it re-competes and is treated as a new request.
- Simultaneous requests: round-robin guarantees that each of 3 continuously requesting masters is granted within 3 transactions.
- busy = (state != IDLE).
- mem_ready asserted outside ACCESS is ignored.

Test Plan:
- Reset release, req=3'b000 for 10 cycles -> sel=0, mem_en=0, ack=0, busy=0 throughout.
- req=3'b001, we=0, addr0=0x100, mem_ready high in the first ACCESS cycle with mem_rdata=-64'sd2 -> mem_en for 1 cycle with mem_addr=0x100, mem_we=0; next cycle ack=3'b001, rdata=-2, err=0; total 3 cycles.
- req=3'b111 held, each requester re-requesting after its ack, mem_ready always 1 -> grant order 0,1,2,0,1,2; sel sequence 1,2,3,1,2,3.
- req=3'b010, we=3'b010, wdata1=64'sd3, mem_ready delayed 4 cycles -> mem_we=1 and mem_wdata=3 stable for 5 cycles; then ack=3'b010; rdata unchanged from its previous value.
- req=3'b100, mem_ready stuck at 0, MAX_WAIT=8 -> mem_en high exactly 8 cycles; then ack=3'b100 with err=1; rr_ptr moves to 0.
- rst_n pulsed low during ACCESS of requester 1 -> outputs cleared immediately, no ack issued; after release, a pending req=3'b011 is granted to requester 0.
